s2p_rx: RTL

Serial-to-parallel receiver for the LED/GPIO serial link. It samples the four-wire stream (shift clock, serial data, active-low clear, load enable) that the parallel-to-serial LED driver emits, and reassembles the parallel word in the system `clk` domain. It sits on the far side of the serial link, either as a board-side receiver model or as a loopback checker. It reports each latched word with a one-cycle valid strobe, plus framing and overflow status.

---
 rtl/s2p_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/s2p_rx.sv
`default_nettype none
// ============================================================================
// Module   : s2p_rx
// Function : serial-to-parallel receiver for the LED/GPIO four-wire link.
// Revision : 1.0
// ============================================================================
module s2p_rx #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 5,
  parameter bit DIR             = 1'b0,
  parameter bit INVERT          = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sdin,
  input  logic                 sclrn,
  input  logic                 sen,
  output logic [DATA_BITS-1:0] pdata,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 busy
);

  localparam logic [DATA_COUNT_BITS-1:0] c_full_cnt = DATA_COUNT_BITS'(DATA_BITS);
  localparam logic [DATA_COUNT_BITS-1:0] c_one_cnt  = DATA_COUNT_BITS'(1);

  // Line order in the synchroniser vectors: {sen, sclrn, sdin, sclk}
  logic [3:0]                 r_meta;
  logic [3:0]                 r_sync;
  logic [1:0]                 r_prev;
  logic [1:0]                 r_settle;
  logic [DATA_BITS-1:0]       r_sr;
  logic [DATA_COUNT_BITS-1:0] r_cnt;
  logic [DATA_BITS-1:0]       r_pdata;
  logic                       r_valid;
  logic                       r_frame_err;
  logic                       r_overflow;

  logic                       w_settled;
  logic                       w_sclk_ev;
  logic                       w_sen_ev;
  logic                       w_clear;
  logic [DATA_BITS-1:0]       w_sr_shifted;

  // Previous-value flops hold 1 until the pipeline has refilled after reset,
  // so a line already high at release never produces a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_prev   <= 2'b11;
      r_settle <= 2'd0;
    end else begin
      r_meta <= {sen, sclrn, sdin, sclk};
      r_sync <= r_meta;
      if (r_settle != 2'd2) begin
        r_settle <= r_settle + 2'd1;
        r_prev   <= 2'b11;
      end else begin
        r_prev <= {r_sync[3], r_sync[0]};
      end
    end
  end

  assign w_settled = (r_settle == 2'd2);
  assign w_sclk_ev = w_settled & r_sync[0] & ~r_prev[0];
  assign w_sen_ev  = w_settled & r_sync[3] & ~r_prev[1];
  assign w_clear   = ~r_sync[2];

  generate
    if (DIR == 1'b0) begin : g_msb_first
      assign w_sr_shifted = {r_sr[DATA_BITS-2:0], r_sync[1]};
    end else begin : g_lsb_first
      assign w_sr_shifted = {r_sync[1], r_sr[DATA_BITS-1:1]};
    end
  endgenerate

  // Latch samples the pre-update sr/cnt, so simultaneous shift or clear
  // below only affects the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr        <= '0;
      r_cnt       <= '0;
      r_pdata     <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid <= w_sen_ev;
      if (w_sen_ev) begin
        r_pdata     <= INVERT ? ~r_sr : r_sr;
        r_frame_err <= (r_cnt != c_full_cnt);
      end

      if (w_clear) begin
        r_sr       <= '0;
        r_cnt      <= '0;
        r_overflow <= 1'b0;
      end else if (w_sclk_ev) begin
        r_sr <= w_sr_shifted;
        if (w_sen_ev) begin
          r_cnt      <= c_one_cnt;
          r_overflow <= 1'b0;
        end else if (r_cnt == c_full_cnt) begin
          r_overflow <= 1'b1;
        end else begin
          r_cnt <= r_cnt + c_one_cnt;
        end
      end else if (w_sen_ev) begin
        r_cnt      <= '0;
        r_overflow <= 1'b0;
      end
    end
  end

  assign pdata     = r_pdata;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign busy      = (r_cnt != '0);

endmodule
`default_nettype wire
